// File: rtl/div_io_pkg.sv
// rtl/div_io_pkg.sv - shared states, default widths and counter sizing for div_stream_io
package div_io_pkg;

   localparam int DEF_BUS_WIDTH = 8;
   localparam int DEF_OP_WIDTH  = 32;
   localparam int DEF_RES_WIDTH = 64;

   typedef enum logic [2:0] {
      IDLE,
      LOAD,
      START,
      WAIT,
      SEND,
      DRAIN
   } state_t;

   // Beat counter width, one spare bit so the terminal count never wraps.
   function automatic int beat_cnt_w(input int n_in, input int n_out);
      return $clog2((n_in > n_out) ? n_in : n_out) + 1;
   endfunction

endpackage

// File: rtl/div_stream_io_if.sv
// rtl/div_stream_io_if.sv - pin-side stream and core-side handshake bundle for div_stream_io
interface div_stream_io_if
   import div_io_pkg::*;
#(
   parameter int BUS_WIDTH = DEF_BUS_WIDTH,
   parameter int OP_WIDTH  = DEF_OP_WIDTH,
   parameter int RES_WIDTH = DEF_RES_WIDTH
);

   logic                 push_in;
   logic [BUS_WIDTH-1:0] data_in_in;
   logic                 sign;
   logic                 select;
   logic [BUS_WIDTH-1:0] data_out_out;
   logic                 pull_out;
   logic                 sign_out;
   logic                 frame_err;
   logic                 core_start;
   logic [OP_WIDTH-1:0]  core_a;
   logic [OP_WIDTH-1:0]  core_b;
   logic                 core_sign;
   logic                 core_select;
   logic                 core_done;
   logic [RES_WIDTH-1:0] core_result;

   modport slave (
      input  push_in, data_in_in, sign, select, core_done, core_result,
      output data_out_out, pull_out, sign_out, frame_err,
             core_start, core_a, core_b, core_sign, core_select
   );

   modport master (
      output push_in, data_in_in, sign, select, core_done, core_result,
      input  data_out_out, pull_out, sign_out, frame_err,
             core_start, core_a, core_b, core_sign, core_select
   );

endinterface

// File: rtl/div_stream_io_par2ser.sv
// rtl/div_stream_io_par2ser.sv - loadable RES_WIDTH to BUS_WIDTH right-shift serialiser, LSB beat first
module par2ser
   import div_io_pkg::*;
#(
   parameter int BUS_WIDTH = DEF_BUS_WIDTH,
   parameter int RES_WIDTH = DEF_RES_WIDTH
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 i_load,
   input  logic [RES_WIDTH-1:0] i_data,
   output logic [BUS_WIDTH-1:0] o_data,
   output logic                 o_pull,
   output logic                 o_last
);

   localparam int             NO   = RES_WIDTH / BUS_WIDTH;
   localparam int             CW   = beat_cnt_w(NO, NO);
   localparam logic [CW-1:0]  LAST = CW'(NO - 1);

   logic [RES_WIDTH-1:0] r_sh;
   logic [CW-1:0]        r_cnt;
   logic                 r_busy;
   logic                 r_first;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_sh    <= '0;
         r_cnt   <= '0;
         r_busy  <= 1'b0;
         r_first <= 1'b0;
      end else if (i_load) begin
         r_sh    <= i_data;
         r_cnt   <= '0;
         r_busy  <= 1'b1;
         r_first <= 1'b1;
      end else if (r_busy) begin
         r_sh    <= r_sh >> BUS_WIDTH;
         r_cnt   <= r_cnt + 1'b1;
         r_first <= 1'b0;
         if (r_cnt == LAST) begin
            r_busy <= 1'b0;
         end
      end
   end

   // Pins read zero whenever no result is being shifted out.
   assign o_data = r_busy ? r_sh[BUS_WIDTH-1:0] : '0;
   assign o_pull = r_busy & r_first;
   assign o_last = r_busy && (r_cnt == LAST);

endmodule

// File: rtl/div_stream_io.sv
// rtl/div_stream_io.sv - byte-stream front-end: deserialise operands, launch divider core, serialise result
module div_stream_io
   import div_io_pkg::*;
#(
   parameter int BUS_WIDTH = DEF_BUS_WIDTH,
   parameter int OP_WIDTH  = DEF_OP_WIDTH,
   parameter int RES_WIDTH = DEF_RES_WIDTH
) (
   input logic            clk,
   input logic            rst_n,
   div_stream_io_if.slave io
);

   localparam int            NI      = OP_WIDTH / BUS_WIDTH;
   localparam int            NO      = RES_WIDTH / BUS_WIDTH;
   localparam int            CW      = beat_cnt_w(2 * NI, NO);
   localparam logic [CW-1:0] LAST_IN = CW'(2 * NI - 1);

   state_t                r_state;
   state_t                w_next;
   logic [CW-1:0]         r_cnt;
   logic [2*OP_WIDTH-1:0] r_ops;
   logic                  r_sign;
   logic                  r_select;
   logic                  r_sign_out;
   logic                  r_frame_err;
   logic                  r_push_d;
   logic                  w_shift;
   logic                  w_clear;
   logic                  w_err;
   logic                  w_load;
   logic                  w_rise;
   logic                  w_send_last;

   assign w_rise = io.push_in & ~r_push_d;

   always_comb begin
      w_next  = r_state;
      w_shift = 1'b0;
      w_clear = 1'b0;
      w_err   = 1'b0;
      w_load  = 1'b0;
      case (r_state)
         IDLE: begin
            if (io.push_in) begin
               w_shift = 1'b1;
               w_next  = LOAD;
            end
         end
         LOAD: begin
            if (io.push_in) begin
               w_shift = 1'b1;
               if (r_cnt == LAST_IN) begin
                  w_next = START;
               end
            end else begin
               w_err   = 1'b1;
               w_clear = 1'b1;
               w_next  = IDLE;
            end
         end
         START: begin
            w_err  = w_rise;
            w_next = WAIT;
         end
         WAIT: begin
            w_err = w_rise;
            if (io.core_done) begin
               w_load = 1'b1;
               w_next = SEND;
            end
         end
         SEND: begin
            w_err = w_rise;
            // An overlong frame still on the pins must not look like a new one.
            if (w_send_last) begin
               w_next = io.push_in ? DRAIN : IDLE;
            end
         end
         DRAIN: begin
            if (!io.push_in) begin
               w_next = IDLE;
            end
         end
         default: w_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= IDLE;
         r_cnt       <= '0;
         r_ops       <= '0;
         r_sign      <= 1'b0;
         r_select    <= 1'b0;
         r_sign_out  <= 1'b0;
         r_frame_err <= 1'b0;
         r_push_d    <= 1'b0;
      end else begin
         r_state     <= w_next;
         r_frame_err <= w_err;
         r_push_d    <= io.push_in;
         if (w_clear) begin
            r_ops <= '0;
         end else if (w_shift) begin
            r_ops <= {r_ops[2*OP_WIDTH-BUS_WIDTH-1:0], io.data_in_in};
         end
         if (w_shift) begin
            r_cnt <= (r_state == IDLE) ? CW'(1) : r_cnt + 1'b1;
         end
         if (r_state == IDLE && io.push_in) begin
            r_sign     <= io.sign;
            r_select   <= io.select;
            r_sign_out <= io.sign;
         end
      end
   end

   assign io.core_start  = (r_state == START);
   assign io.core_a      = r_ops[2*OP_WIDTH-1:OP_WIDTH];
   assign io.core_b      = r_ops[OP_WIDTH-1:0];
   assign io.core_sign   = r_sign;
   assign io.core_select = r_select;
   assign io.sign_out    = r_sign_out;
   assign io.frame_err   = r_frame_err;

   par2ser #(
      .BUS_WIDTH (BUS_WIDTH),
      .RES_WIDTH (RES_WIDTH)
   ) u_par2ser (
      .clk    (clk),
      .rst_n  (rst_n),
      .i_load (w_load),
      .i_data (io.core_result),
      .o_data (io.data_out_out),
      .o_pull (io.pull_out),
      .o_last (w_send_last)
   );

endmodule

// File: tb/tb_div_stream_io.sv
// tb/tb_div_stream_io.sv - scoreboard bench for div_stream_io with a random-latency core model
module tb_div_stream_io;

   localparam int BW  = 8;
   localparam int OW  = 32;
   localparam int RW  = 64;
   localparam int NI  = OW / BW;
   localparam int NO  = RW / BW;
   localparam int BW2 = 16;
   localparam int NO2 = RW / BW2;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   div_stream_io_if #(.BUS_WIDTH(BW),  .OP_WIDTH(OW), .RES_WIDTH(RW)) bus8 ();
   div_stream_io_if #(.BUS_WIDTH(BW2), .OP_WIDTH(OW), .RES_WIDTH(RW)) bus16 ();

   div_stream_io #(.BUS_WIDTH(BW),  .OP_WIDTH(OW), .RES_WIDTH(RW)) u_dut8  (.clk(clk), .rst_n(rst_n), .io(bus8));
   div_stream_io #(.BUS_WIDTH(BW2), .OP_WIDTH(OW), .RES_WIDTH(RW)) u_dut16 (.clk(clk), .rst_n(rst_n), .io(bus16));

   typedef struct {
      logic [OW-1:0] a;
      logic [OW-1:0] b;
      logic          sgn;
      logic          sel;
      int            t_last;
   } op_exp_t;

   typedef struct {
      logic [BW-1:0] data;
      logic          pull;
      logic          sgn;
      int            cyc;
      int            idx;
   } beat_exp_t;

   op_exp_t   op_q[$];
   beat_exp_t beat_q[$];
   beat_exp_t mon_b;

   int checks = 0, failures = 0, cyc = 0;
   int inflight = 0, beats_done = 0;
   int err_exp = 0, err_seen = 0, start_exp = 0, start_seen = 0;
   bit use_fixed = 0;
   logic [RW-1:0] fixed_result = 64'h0123456789ABCDEF;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic check_zero8(input string tag);
      check({tag, "_data_out"},   bus8.data_out_out, 0);
      check({tag, "_pull_out"},   bus8.pull_out, 0);
      check({tag, "_sign_out"},   bus8.sign_out, 0);
      check({tag, "_frame_err"},  bus8.frame_err, 0);
      check({tag, "_core_start"}, bus8.core_start, 0);
      check({tag, "_core_a"},     bus8.core_a, 0);
      check({tag, "_core_b"},     bus8.core_b, 0);
      check({tag, "_core_sign"},  bus8.core_sign, 0);
      check({tag, "_core_sel"},   bus8.core_select, 0);
   endtask

   always @(negedge clk) begin
      if (rst_n) begin
         if (bus8.frame_err)  err_seen++;
         if (bus8.core_start) start_seen++;
      end
   end

   // Output monitor: every cycle either an expected beat or idle pins.
   always @(negedge clk) begin
      if (rst_n) begin
         if (beat_q.size() != 0 && beat_q[0].cyc == cyc) begin
            mon_b = beat_q.pop_front();
            check("beat_data", bus8.data_out_out, mon_b.data);
            check("beat_pull", bus8.pull_out, mon_b.pull);
            check("sign_out",  bus8.sign_out, mon_b.sgn);
            beats_done = mon_b.idx + 1;
            if (mon_b.idx == NO - 1) inflight--;
         end else begin
            check("idle_data", bus8.data_out_out, 0);
            check("idle_pull", bus8.pull_out, 0);
         end
      end
   end

   // Core model: checks launched operands, answers after a random latency.
   initial begin : core_side
      op_exp_t       e;
      logic [RW-1:0] res;
      int            d;
      bus8.core_done   = 1'b0;
      bus8.core_result = '0;
      forever begin
         @(negedge clk);
         if (rst_n && bus8.core_start) begin
            if (op_q.size() == 0) begin
               check("unexpected_core_start", 1, 0);
            end else begin
               e = op_q.pop_front();
               check("core_a", bus8.core_a, e.a);
               check("core_b", bus8.core_b, e.b);
               check("core_sign", bus8.core_sign, e.sgn);
               check("core_select", bus8.core_select, e.sel);
               check("start_latency", cyc, e.t_last + 1);
               repeat ($urandom_range(1, 4)) @(posedge clk);
               #1;
               res = use_fixed ? fixed_result : {$urandom, $urandom};
               bus8.core_result = res;
               bus8.core_done   = 1'b1;
               d = cyc;
               for (int j = 0; j < NO; j++) begin
                  beat_q.push_back('{data: res[j*BW +: BW], pull: (j == 0), sgn: e.sgn, cyc: d + 1 + j, idx: j});
               end
               @(posedge clk);
               #1;
               bus8.core_done   = 1'b0;
               bus8.core_result = {$urandom, $urandom};
            end
         end
      end
   end

   task automatic drive_beats(input logic [OW-1:0] a, input logic [OW-1:0] b, input logic sg,
                              input logic sl, input int nbeats, input int extra);
      logic [2*OW-1:0] ops;
      ops = {a, b};
      for (int k = 0; k < nbeats; k++) begin
         bus8.push_in    = 1'b1;
         bus8.data_in_in = ops[(2*NI-1-k)*BW +: BW];
         bus8.sign       = (k == 0) ? sg : 1'($urandom);
         bus8.select     = (k == 0) ? sl : 1'($urandom);
         if (k == 2*NI - 1) begin
            op_q.push_back('{a: a, b: b, sgn: sg, sel: sl, t_last: cyc});
            start_exp++;
            inflight++;
         end
         @(posedge clk);
         #1;
      end
      for (int k = 0; k < extra; k++) begin
         bus8.data_in_in = BW'($urandom);
         @(posedge clk);
         #1;
      end
      bus8.push_in    = 1'b0;
      bus8.data_in_in = BW'($urandom);
      if (nbeats < 2*NI) err_exp++;
   endtask

   task automatic wait_idle();
      int t;
      t = 0;
      do begin
         @(posedge clk);
         #1;
         t++;
      end while (inflight != 0 && t < 300);
      if (inflight != 0) check("wait_idle_timeout", inflight, 0);
      @(negedge clk);
      #1;
      check("err_count", err_seen, err_exp);
      check("start_count", start_seen, start_exp);
      @(posedge clk);
      #1;
   endtask

   task automatic send_frame(input logic [OW-1:0] a, input logic [OW-1:0] b, input logic sg,
                             input logic sl, input int nbeats, input int extra, input bit busy_push);
      drive_beats(a, b, sg, sl, nbeats, extra);
      if (busy_push) begin
         @(posedge clk);
         #1;
         bus8.push_in = 1'b1;
         err_exp++;
         repeat (2) begin
            @(posedge clk);
            #1;
         end
         bus8.push_in = 1'b0;
      end
      wait_idle();
   endtask

   initial begin : watchdog
      #500000;
      $display("FAIL global_timeout cycle=%0d", cyc);
      $fatal(1, "global timeout");
   end

   initial begin : stim
      int t, nb, ex;
      logic [RW-1:0] r16;
      bus8.push_in = 1'b0;  bus8.data_in_in = '0;  bus8.sign = 1'b0;  bus8.select = 1'b0;
      bus16.push_in = 1'b0; bus16.data_in_in = '0; bus16.sign = 1'b0; bus16.select = 1'b0;
      bus16.core_done = 1'b0; bus16.core_result = '0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check_zero8("reset");
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      use_fixed = 1;
      send_frame(32'h3F800000, 32'h40000000, 1'b0, 1'b1, 2*NI, 0, 0);
      use_fixed = 0;
      send_frame($urandom, $urandom, 1'b1, 1'b0, 5, 0, 0);
      send_frame($urandom, $urandom, 1'b0, 1'b0, 2*NI, 0, 0);
      send_frame($urandom, $urandom, 1'b1, 1'b1, 2*NI, 0, 1);
      send_frame($urandom, $urandom, 1'b0, 1'b1, 2*NI, 3, 0);
      send_frame($urandom, $urandom, 1'b1, 1'b0, 2*NI, 20, 0);
      send_frame($urandom, $urandom, 1'b0, 1'b0, 1, 0, 0);

      for (int i = 0; i < 25; i++) begin
         nb = ($urandom_range(0, 9) < 7) ? 2*NI : $urandom_range(1, 2*NI - 1);
         ex = (nb == 2*NI) ? $urandom_range(0, 4) : 0;
         send_frame($urandom, $urandom, 1'($urandom), 1'($urandom), nb, ex,
                    (nb == 2*NI && ex == 0) ? 1'($urandom) : 1'b0);
      end

      // Stray core_done in IDLE must produce nothing.
      bus8.core_done = 1'b1;
      bus8.core_result = {$urandom, $urandom};
      @(posedge clk);
      #1;
      bus8.core_done = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      wait_idle();

      // Reset in the middle of a result send.
      beats_done = 0;
      drive_beats($urandom, $urandom, 1'b1, 1'b1, 2*NI, 0);
      t = 0;
      while (beats_done < 4 && t < 200) begin
         @(posedge clk);
         #1;
         t++;
      end
      check("reset_wait_beats", beats_done >= 4, 1);
      #1;
      rst_n = 1'b0;
      #1;
      check_zero8("midsend_reset");
      beat_q.delete();
      inflight = 0;
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      repeat (6) @(posedge clk);
      #1;
      @(negedge clk);
      check_zero8("after_reset");
      @(posedge clk);
      #1;
      send_frame($urandom, $urandom, 1'b1, 1'b0, 2*NI, 0, 0);

      // 16-bit bus instance, directed.
      bus16.push_in = 1'b1;
      bus16.select = 1'b1;
      bus16.sign = 1'b0;
      bus16.data_in_in = 16'h3F80; @(posedge clk); #1;
      bus16.select = 1'b0;
      bus16.data_in_in = 16'h0000; @(posedge clk); #1;
      bus16.data_in_in = 16'h4000; @(posedge clk); #1;
      bus16.data_in_in = 16'h0000;
      t = cyc;
      @(posedge clk); #1;
      bus16.push_in = 1'b0;
      @(negedge clk);
      check("w16_core_start", bus16.core_start, 1);
      check("w16_start_cycle", cyc, t + 1);
      check("w16_core_a", bus16.core_a, 32'h3F800000);
      check("w16_core_b", bus16.core_b, 32'h40000000);
      check("w16_core_select", bus16.core_select, 1);
      @(posedge clk); #1;
      r16 = 64'h0123456789ABCDEF;
      bus16.core_result = r16;
      bus16.core_done = 1'b1;
      @(posedge clk); #1;
      bus16.core_done = 1'b0;
      for (int j = 0; j < NO2; j++) begin
         @(negedge clk);
         check("w16_beat", bus16.data_out_out, r16[j*BW2 +: BW2]);
         check("w16_pull", bus16.pull_out, (j == 0));
      end
      @(negedge clk);
      check("w16_idle_data", bus16.data_out_out, 0);
      check("w16_idle_pull", bus16.pull_out, 0);

      repeat (3) @(posedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/div_stream_io.md
# div_stream_io

Parametrised byte-stream front-end for the divider core. It deserialises a dividend/divisor frame from the narrow input pins into parallel operands, launches the core with a single-cycle start pulse, then serialises the core's result back onto the narrow output pins, with a frame marker. It generalises the fixed 8-bit/32-bit/64-bit pin protocol of the current top in bus width and operand/result width, and adds abort detection and a protocol-error flag.

## Interface
- BUS_WIDTH, 8: pin beat width in bits.
- OP_WIDTH, 32: width of each operand. Must be a multiple of BUS_WIDTH.
- RES_WIDTH, 64: result width (quotient and remainder). Must be a multiple of BUS_WIDTH.
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- push_in  in  1  input frame valid. Held high for the whole frame.
- data_in_in  in  BUS_WIDTH  input beat, MSB-first within each operand.
- sign  in  1  signed-operation request. Sampled on beat 0.
- select  in  1  mode: 0 = radix-2 integer, 1 = fp32. Sampled on beat 0.
- data_out_out  out  BUS_WIDTH  result beat, LSB-first. 0 when not sending.
- pull_out  out  1  high only during the cycle that carries result beat 0.
- sign_out  out  1  sign request of the frame being returned. Held until the next frame's beat 0.
- frame_err  out  1  one-cycle pulse on a protocol error.
- core_start  out  1  one-cycle launch pulse to the core.
- core_a, core_b  out  OP_WIDTH  dividend and divisor. Held stable from core_start until core_done.
- core_sign, core_select  out  1  latched sign and select.
- core_done  in  1  one-cycle pulse; core_result is valid in this cycle.
- core_result  in  RES_WIDTH  core result.

## Operation
- Derived constants: NI = OP_WIDTH/BUS_WIDTH beats per operand; NO = RES_WIDTH/BUS_WIDTH result beats.
- States:
  - IDLE: push_in=1 captures beat 0 and goes to LOAD.
  - LOAD: captures one beat per cycle. Beats 0..NI-1 fill core_a; beats NI..2NI-1 fill core_b. After beat 2NI-1 → START.
  - START: core_start=1 for one cycle → WAIT.
  - WAIT: core_done latches core_result → SEND.
  - SEND: emits NO beats, then → IDLE, or → DRAIN if push_in is still high.
  - DRAIN: waits for push_in=0 → IDLE.
- Abort: push_in=0 in LOAD before beat 2NI-1 → frame_err pulse, operands discarded, → IDLE. No core_start is issued.
- Extra beats: push_in still high after beat 2NI-1 → beats are ignored, no error. The FSM returns through DRAIN so the overlong frame is never taken as a new frame.
- Push while busy: push_in=1 in START, WAIT or SEND → frame_err pulses once on the rising edge of push_in. The beats are ignored and the current transaction finishes normally.
- Stray core_done: core_done outside WAIT is ignored.
- Reset: asynchronous, from any state → IDLE. Every output goes to 0: data_out_out, pull_out, sign_out, frame_err, core_start, core_a, core_b, core_sign, core_select. A result send in progress is truncated.

## Timing
- Beat k is sampled at the rising edge ending input cycle k.
- Last input beat in cycle T → core_start high in cycle T+1. The operands are already stable in cycle T+1.
- core_done in cycle D → pull_out=1 and beat 0 (core_result[BUS_WIDTH-1:0]) in cycle D+1.
- Beat j appears in cycle D+1+j, for j=0..NO-1. The output returns to 0 in cycle D+1+NO.
- Minimum gap between frames: push_in must be low for at least one cycle. The next beat 0 is accepted no earlier than cycle D+1+NO.

## Structure
- Package div_io_pkg holds:
  - the state enum (IDLE, LOAD, START, WAIT, SEND, DRAIN);
  - the default widths;
  - a beat-count function ceil-log2 sizing the beat counter, width $clog2(max(2NI, NO))+1.
- One natural sub-module: par2ser. It is a parametrised RES_WIDTH→BUS_WIDTH loadable right-shift register with a beat counter and a first-beat flag, and it drives data_out_out and pull_out.
- The deserialiser stays inline as a left-shift into {core_a, core_b}.

## Test plan
- Defaults, frame 3F 80 00 00 40 00 00 00 with select=1, sign=0 → core_a=32'h3F800000, core_b=32'h40000000, core_select=1, core_start one cycle after the 8th beat.
- core_done with core_result=64'h0123456789ABCDEF → data_out_out EF,CD,AB,89,67,45,23,01 on eight consecutive cycles, pull_out only with EF, then 0.
- push_in drops after 5 beats → frame_err single pulse, no core_start. A following full frame is accepted correctly.
- push_in raised during SEND → one frame_err pulse, output sequence unchanged. push_in held 3 beats past beat 8 → no error, only one core_start.
- rst_n low mid-SEND, after beat 3 → all outputs 0 immediately. Outputs stay 0 after release until a new frame and core_done.
- BUS_WIDTH=16 variant, frame 3F80 0000 4000 0000 → core_start after 4 beats. Result 64'h0123456789ABCDEF → beats CDEF,89AB,4567,0123.
